lrc_stream: RTL
===============

Name: lrc_stream

Overview:
Parametrised, frame-aware successor to the running LRC block. Accumulates a longitudinal redundancy check over a valid/ready input stream, one frame at a time, delimited by in_last. Emits the finished check word and beat count through a valid/ready result port. Sits between a byte/word source (UART RX, SPI shim) and the consumer that appends or verifies the check word.

Parameters:
WIDTH, 8, data and check-word width in bits (2..32)
MODE, 0, 0 = two's-complement sum LRC, 1 = XOR parity LRC
CNT_W, 16, width of the per-frame beat counter

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat present
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  input word
in_last  input  1  marks final beat of frame
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_lrc  output  WIDTH  finished check word
out_count  output  CNT_W  beats in frame, saturating
out_overflow  output  1  beat counter saturated during frame

Behaviour:
- Reset (async, active-high): state IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_lrc=0, out_count=0, out_overflow=0. in_ready=1 on the first clock after reset release.
- Beat accept = in_valid & in_ready. Every accepted beat counts, including zero-valued and repeated words. No change detection.
- FSM states:
  - IDLE: in_ready=1. An accepted beat goes to ACCUM, or to HOLD if in_last.
  - ACCUM: in_ready=1. Accepted non-last beats stay in ACCUM. An accepted last beat goes to HOLD.
  - HOLD: in_ready=0, out_valid=1. When out_ready=1, go to IDLE and clear acc, cnt and ovf.
- Accumulate:
  - MODE 0: acc <= (acc + in_data) mod 2^WIDTH.
  - MODE 1: acc <= acc ^ in_data.
- Finish, on the accepted last beat. Let s be the accumulate result including that beat.
  - MODE 0: out_lrc <= (~s + 1) mod 2^WIDTH.
  - MODE 1: out_lrc <= s.
  - out_count <= cnt+1, saturating at all-ones.
  - out_overflow <= ovf, OR 1 if this increment would exceed all-ones.
- Latency: out_valid rises the cycle after the last beat is accepted.
- In HOLD, out_lrc, out_count and out_overflow are held stable while out_valid=1 and out_ready=0.
- out_valid falls the cycle after the handshake. in_ready returns in that same cycle, so there is one bubble cycle between frames.
- Counter: cnt increments per accepted beat. At all-ones it holds and sets ovf. ovf is sticky until the result handshake.
- out_ready while out_valid=0 has no effect. in_valid while in HOLD is ignored, and in_data/in_last are not sampled.
- A single-beat frame (in_last on the first beat) is legal: count=1.
- Reset asserted mid-frame or in HOLD: the frame is discarded and all outputs return to reset values immediately (asynchronous).
- in_data may change freely when in_valid=0.

Optional Feature:
Macro LRC_STREAM_CHECK_EN.
- Defined:
  - Adds output port out_ok (1 bit, reset 0).
  - Verify use: the frame includes the transmitted check word as its final beat.
  - On finish, out_ok <= 1 iff s == 0. For MODE 0 this means the sum of all beats is 0 mod 2^WIDTH; for MODE 1 the XOR of all beats is 0.
  - out_ok is valid and held under the same rules as out_lrc.
- Not defined: port absent and no compare logic. All other behaviour is identical.

Test Plan:
- MODE0 W8: beats 0x01, 0x02, 0x03(last), out_ready=1 -> out_valid one cycle after the last accept; out_lrc=0xFA, out_count=3, out_overflow=0.
- MODE0 wrap and zeros: beats 0xFF, 0x00, 0x02(last) -> sum 0x01, out_lrc=0xFF, out_count=3. MODE1, same beats -> out_lrc=0xFD.
- Backpressure: frame 0x80(last), out_ready=0 for 5 cycles -> out_lrc=0x80 and out_count=1 stable, in_ready=0 throughout; handshake on cycle 6 -> next cycle out_valid=0, in_ready=1; new frame 0x10(last) -> out_lrc=0xF0.
- Overflow, CNT_W=2: 5 beats of 0x01, last on the fifth -> out_count=3, out_overflow=1, out_lrc=0xFB; next frame 0x01(last) -> out_overflow=0, out_count=1.
- Async reset: assert rst mid-ACCUM and again during HOLD -> outputs zero immediately; after release, frame 0x05(last) -> out_lrc=0xFB (no stale accumulation).
- LRC_STREAM_CHECK_EN: beats 0x01, 0x02, 0x03, 0xFA(last) -> out_ok=1; same frame ending 0xFB -> out_ok=0, out_lrc=0xFF.

Source files
------------

// File: rtl/lrc_stream.sv
// Frame-aware longitudinal redundancy check over a valid/ready stream.
// Optional verify flag out_ok is enabled by defining LRC_STREAM_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for first beat of a frame
// ACCUM   | frame in progress, accumulating beats
// HOLD    | result presented on out_*, waiting for out_ready
module lrc_stream #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lrc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
`ifdef LRC_STREAM_CHECK_EN
    ,
    output logic             out_ok
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [WIDTH-1:0] DATA_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic             cnt_full;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] lrc_fin;
    logic [CNT_W-1:0] cnt_next;

    assign in_ready  = (state != S_HOLD);
    assign out_valid = (state == S_HOLD);
    assign accept    = in_valid & in_ready;
    assign cnt_full  = &cnt;
    assign cnt_next  = cnt_full ? cnt : cnt + CNT_ONE;

    always_comb begin
        acc_next = acc;
        lrc_fin  = acc;
        if (MODE == 0) begin
            acc_next = acc + in_data;
            lrc_fin  = ~acc_next + DATA_ONE;
        end else begin
            acc_next = acc ^ in_data;
            lrc_fin  = acc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            out_lrc      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
`ifdef LRC_STREAM_CHECK_EN
            out_ok       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        ovf <= ovf | cnt_full;
                        if (in_last) begin
                            state        <= S_HOLD;
                            out_lrc      <= lrc_fin;
                            out_count    <= cnt_next;
                            out_overflow <= ovf | cnt_full;
`ifdef LRC_STREAM_CHECK_EN
                            out_ok       <= (acc_next == '0);
`endif
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    // Result registers keep their value; only frame state clears.
                    if (out_ready) begin
                        state <= S_IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
